// File: rtl/tmds_video_timing.sv
// Video timing recovery behind a TMDS decoder: re-times pixels, tracks the active
// raster position and measures the active resolution until it stays stable.
module tmds_video_timing #(
    parameter int SYNC_POL      = 1,
    parameter int STABLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        locked,
    input  logic        data_valid,
    input  logic        sync_valid,
    input  logic [1:0]  sync,
    input  logic [7:0]  d0,
    input  logic [7:0]  d1,
    input  logic [7:0]  d2,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic [11:0] width,
    output logic [11:0] height,
    output logic        timing_valid
);

    localparam logic [11:0] SAT_MAX    = 12'hFFF;
    localparam logic [3:0]  STABLE_MAX = 4'(STABLE_FRAMES);
    localparam logic        ACTIVE_LVL = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_start;
    logic        w_close;
    logic        w_inc_y;

    logic        w_de_in;
    logic        w_rise;
    logic        w_fall;
    logic        w_vs_next;
    logic        w_vedge;
    logic [11:0] w_line_len;
    logic        w_meas_fall;
    logic        w_have_len_eff;
    logic [11:0] w_first_eff;
    logic        w_bad_eff;
    logic [11:0] w_lines;
    logic        w_same;

    logic [11:0] r_first_len;
    logic        r_have_len;
    logic        r_frame_bad;
    logic [3:0]  r_stable_cnt;

    // The de output register doubles as the previous de_in used for edge detection.
    assign w_de_in    = data_valid & locked;
    assign w_rise     = w_de_in & ~de;
    assign w_fall     = ~w_de_in & de;
    assign w_vs_next  = sync_valid ? sync[1] : vsync;
    assign w_vedge    = (w_vs_next != vsync) && (w_vs_next == ACTIVE_LVL);

    // x still holds the last pixel's column on the fall cycle.
    assign w_line_len = (x == SAT_MAX) ? SAT_MAX : x + 12'd1;
    assign w_meas_fall = w_fall && (r_state == ACTIVE);

    // A line ending in the very cycle the frame closes must still count.
    assign w_have_len_eff = r_have_len | w_meas_fall;
    assign w_first_eff    = r_have_len ? r_first_len : w_line_len;
    assign w_bad_eff      = r_frame_bad
                          | (w_meas_fall & r_have_len & (w_line_len != r_first_len))
                          | ~w_have_len_eff;
    assign w_lines        = (y == SAT_MAX) ? SAT_MAX : y + 12'd1;
    assign w_same         = (w_first_eff == width) && (w_lines == height);

    // Frame tracking state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEEK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame tracking next state and frame open/close strobes.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_close      = 1'b0;
        w_inc_y      = 1'b0;
        if (!locked) begin
            w_state_next = SEEK;
        end else begin
            case (r_state)
                SEEK: begin
                    if (w_vedge) begin
                        w_state_next = ARMED;
                    end else begin
                        w_state_next = SEEK;
                    end
                end
                ARMED: begin
                    if (w_rise) begin
                        w_state_next = ACTIVE;
                        w_start      = 1'b1;
                    end else begin
                        w_state_next = ARMED;
                    end
                end
                ACTIVE: begin
                    if (w_vedge) begin
                        w_close = 1'b1;
                        if (w_rise) begin
                            w_state_next = ACTIVE;
                            w_start      = 1'b1;
                        end else begin
                            w_state_next = ARMED;
                        end
                    end else if (w_rise) begin
                        w_state_next = ACTIVE;
                        w_inc_y      = 1'b1;
                    end else begin
                        w_state_next = ACTIVE;
                    end
                end
                default: begin
                    w_state_next = SEEK;
                end
            endcase
        end
    end

    // Pixel and data-enable pipeline stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r  <= 8'd0;
            g  <= 8'd0;
            b  <= 8'd0;
            de <= 1'b0;
        end else begin
            r  <= d2;
            g  <= d1;
            b  <= d0;
            de <= w_de_in;
        end
    end

    // Sync levels only move on control words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else if (sync_valid) begin
            hsync <= sync[0];
            vsync <= sync[1];
        end else begin
            hsync <= hsync;
            vsync <= vsync;
        end
    end

    // Raster position and frame start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= 12'd0;
            y           <= 12'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_start;
            if (w_rise) begin
                x <= 12'd0;
            end else if (w_de_in && (x != SAT_MAX)) begin
                x <= x + 12'd1;
            end else begin
                x <= x;
            end
            if (w_start) begin
                y <= 12'd0;
            end else if (w_inc_y && (y != SAT_MAX)) begin
                y <= y + 12'd1;
            end else begin
                y <= y;
            end
        end
    end

    // Per-frame line length consistency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first_len <= 12'd0;
            r_have_len  <= 1'b0;
            r_frame_bad <= 1'b0;
        end else if (w_start) begin
            r_first_len <= 12'd0;
            r_have_len  <= 1'b0;
            r_frame_bad <= 1'b0;
        end else if (w_meas_fall) begin
            if (!r_have_len) begin
                r_first_len <= w_line_len;
                r_have_len  <= 1'b1;
            end else if (w_line_len != r_first_len) begin
                r_frame_bad <= 1'b1;
            end else begin
                r_frame_bad <= r_frame_bad;
            end
        end else begin
            r_first_len <= r_first_len;
        end
    end

    // Resolution results and stability qualification, evaluated on frame close.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            width        <= 12'd0;
            height       <= 12'd0;
            r_stable_cnt <= 4'd0;
            timing_valid <= 1'b0;
        end else begin
            timing_valid <= locked && (r_stable_cnt >= STABLE_MAX);
            if (!locked) begin
                r_stable_cnt <= 4'd0;
            end else if (w_close) begin
                if (!w_bad_eff) begin
                    width  <= w_first_eff;
                    height <= w_lines;
                    if (w_same) begin
                        r_stable_cnt <= (r_stable_cnt >= STABLE_MAX) ? STABLE_MAX
                                                                     : r_stable_cnt + 4'd1;
                    end else begin
                        r_stable_cnt <= 4'd1;
                    end
                end else begin
                    r_stable_cnt <= 4'd0;
                end
            end else begin
                r_stable_cnt <= r_stable_cnt;
            end
        end
    end

endmodule

// File: tb/tb_tmds_video_timing.sv
// Scoreboard bench for tmds_video_timing: a frame generator drives random rasters,
// a reference model queues the expected outputs, and a monitor compares them.
module tb_tmds_video_timing;

    localparam int STABLE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        locked;
    logic        data_valid;
    logic        sync_valid;
    logic [1:0]  sync;
    logic [7:0]  d0, d1, d2;
    logic [7:0]  r, g, b;
    logic        de, hsync, vsync, frame_start, timing_valid;
    logic [11:0] x, y, width, height;

    tmds_video_timing dut (
        .clk(clk), .reset(reset), .locked(locked), .data_valid(data_valid),
        .sync_valid(sync_valid), .sync(sync), .d0(d0), .d1(d1), .d2(d2),
        .r(r), .g(g), .b(b), .de(de), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .frame_start(frame_start), .width(width), .height(height),
        .timing_valid(timing_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pr, pg, pb;
        logic        de, hs, vs, fs, tv;
        logic [11:0] x, y, w, h;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: spec-level view of the raster and the measured frames.
    localparam int P_SEEK = 0, P_ARMED = 1, P_ACTIVE = 2;
    int   m_phase, m_x, m_y, m_run, m_w, m_h, m_stable;
    logic m_de_prev, m_hs, m_vs, m_fs;
    int   m_lines[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic reset_model();
        m_phase = P_SEEK; m_x = 0; m_y = 0; m_run = 0; m_w = 0; m_h = 0; m_stable = 0;
        m_de_prev = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_fs = 1'b0;
        m_lines.delete();
    endtask

    task automatic start_frame();
        m_phase = P_ACTIVE; m_y = 0; m_fs = 1'b1;
        m_lines.delete();
    endtask

    task automatic close_frame();
        int  hh, fw;
        bit  bad;
        hh  = (m_y < 4095) ? m_y + 1 : 4095;
        bad = (m_lines.size() == 0);
        fw  = bad ? 0 : m_lines[0];
        foreach (m_lines[i]) if (m_lines[i] != fw) bad = 1;
        if (bad) begin
            m_stable = 0;
        end else begin
            if (fw == m_w && hh == m_h) m_stable = (m_stable < STABLE) ? m_stable + 1 : STABLE;
            else m_stable = 1;
            m_w = fw; m_h = hh;
        end
    endtask

    // One clock of stimulus plus its expected registered response.
    task automatic cyc(input logic lk, input logic dv, input logic sv, input logic [1:0] sy);
        exp_t e;
        logic de_in, rise, fall, vs_new, vedge;
        @(negedge clk); #1;
        reset = 1'b0; locked = lk; data_valid = dv; sync_valid = sv; sync = sy;
        d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        de_in  = dv & lk;
        rise   = de_in & ~m_de_prev;
        fall   = ~de_in & m_de_prev;
        vs_new = sv ? sy[1] : m_vs;
        vedge  = (vs_new != m_vs) && vs_new;
        e.tv   = lk && (m_stable >= STABLE);
        if (sv) begin m_hs = sy[0]; m_vs = sy[1]; end
        if (rise) begin
            m_x = 0; m_run = 1;
        end else if (de_in) begin
            if (m_x < 4095) m_x++;
            if (m_run < 4095) m_run++;
        end
        if (fall && m_phase == P_ACTIVE) m_lines.push_back(m_run);
        m_fs = 1'b0;
        if (!lk) begin
            m_phase = P_SEEK; m_stable = 0;
        end else if (m_phase == P_SEEK) begin
            if (vedge) m_phase = P_ARMED;
        end else if (m_phase == P_ARMED) begin
            if (rise) start_frame();
        end else begin
            if (vedge) begin
                close_frame();
                if (rise) start_frame(); else m_phase = P_ARMED;
            end else if (rise && m_y < 4095) begin
                m_y++;
            end
        end
        e.pr = d2; e.pg = d1; e.pb = d0; e.de = de_in; e.hs = m_hs; e.vs = m_vs;
        e.fs = m_fs; e.x = 12'(m_x); e.y = 12'(m_y); e.w = 12'(m_w); e.h = 12'(m_h);
        q.push_back(e);
        m_de_prev = de_in;
    endtask

    task automatic rst_cyc();
        @(negedge clk); #1;
        reset = 1'b1;
        d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        reset_model();
        q.push_back('0);
    endtask

    task automatic async_reset();
        @(negedge clk); #3;
        reset = 1'b1;
        #1;
        chk("async_rst_rgb", {8'd0, r, g, b}, 32'd0);
        chk("async_rst_ctl", {27'd0, de, hsync, vsync, frame_start, timing_valid}, 32'd0);
        chk("async_rst_xy", {8'd0, x, y}, 32'd0);
        chk("async_rst_wh", {8'd0, width, height}, 32'd0);
        reset_model();
        q.push_back('0);
    endtask

    // One frame: vertical sync (or a sync coincident with the first pixel), then lines.
    task automatic send_frame(input int w, input int h, input int bad_row, input int bad_len,
                              input int coinc, input int drop_row, input int rst_row);
        int vb, hb, len;
        vb = $urandom_range(2, 6);
        if (coinc == 0) begin
            cyc(1'b1, 1'b0, 1'b1, 2'b10);
            cyc(1'b1, 1'b0, 1'b1, 2'b10);
        end
        repeat (vb) cyc(1'b1, 1'b0, 1'b1, 2'b00);
        for (int row = 0; row < h; row++) begin
            len = (row == bad_row) ? bad_len : w;
            for (int col = 0; col < len; col++) begin
                if (row == rst_row && col == 2) begin
                    async_reset();
                    rst_cyc();
                    rst_cyc();
                    return;
                end
                if (coinc != 0 && row == 0 && col == 0) cyc(1'b1, 1'b1, 1'b1, 2'b10);
                else cyc(!(row == drop_row && col == 4), 1'b1, 1'b0, 2'b00);
            end
            hb = $urandom_range(2, 5);
            cyc(1'b1, 1'b0, 1'b1, 2'b01);
            repeat (hb) cyc(1'b1, 1'b0, 1'b1, 2'b00);
        end
    endtask

    task automatic tail();
        cyc(1'b1, 1'b0, 1'b1, 2'b10);
        repeat (6) cyc(1'b1, 1'b0, 1'b1, 2'b00);
    endtask

    // Monitor: one queued expectation per clock, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rgb", {8'd0, r, g, b}, {8'd0, e.pr, e.pg, e.pb});
                chk("de", {31'd0, de}, {31'd0, e.de});
                chk("hsync", {31'd0, hsync}, {31'd0, e.hs});
                chk("vsync", {31'd0, vsync}, {31'd0, e.vs});
                chk("x", {20'd0, x}, {20'd0, e.x});
                chk("y", {20'd0, y}, {20'd0, e.y});
                chk("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
                chk("width", {20'd0, width}, {20'd0, e.w});
                chk("height", {20'd0, height}, {20'd0, e.h});
                chk("timing_valid", {31'd0, timing_valid}, {31'd0, e.tv});
            end
        end
    end

    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected stimulus completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int w, h, nf;
        reset = 1'b1; locked = 1'b0; data_valid = 1'b0; sync_valid = 1'b0;
        sync = 2'b00; d0 = 8'd0; d1 = 8'd0; d2 = 8'd0;
        reset_model();
        repeat (3) rst_cyc();
        repeat (4) cyc(1'b1, 1'b0, 1'b1, 2'b00);

        // Stable raster, then a frame with one short line.
        repeat (3) send_frame(12, 6, -1, 0, 0, -1, -1);
        send_frame(12, 6, 3, 11, 0, -1, -1);
        repeat (3) send_frame(12, 6, -1, 0, 0, -1, -1);

        // Lock lost for one cycle mid-frame.
        send_frame(12, 6, -1, 0, 0, 2, -1);
        repeat (3) send_frame(12, 6, -1, 0, 0, -1, -1);

        // Resolution change, then sync coincident with the first pixel.
        repeat (3) send_frame(16, 8, -1, 0, 0, -1, -1);
        repeat (2) send_frame(16, 8, -1, 0, 1, -1, -1);
        send_frame(16, 8, -1, 0, 0, -1, -1);

        // Over-wide lines saturate the column and measured width.
        send_frame(4100, 2, -1, 0, 0, -1, -1);
        send_frame(4100, 2, -1, 0, 0, -1, -1);

        // Random rasters, occasionally corrupted or sync-coincident.
        for (int k = 0; k < 5; k++) begin
            w  = $urandom_range(4, 20);
            h  = $urandom_range(2, 8);
            nf = $urandom_range(2, 3);
            for (int f = 0; f < nf; f++)
                send_frame(w, h, ($urandom_range(0, 3) == 0) ? h - 1 : -1, w - 1,
                           int'($urandom_range(0, 1)), -1, -1);
        end

        // Asynchronous reset mid-line, then recovery.
        send_frame(12, 6, -1, 0, 0, -1, -1);
        send_frame(12, 6, -1, 0, 0, -1, 2);
        repeat (3) send_frame(12, 6, -1, 0, 0, -1, -1);
        tail();

        @(negedge clk); #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_video_timing.md
TMDS_VIDEO_TIMING -- requirements
Module: tmds_video_timing

Interface
REQ-001 SHALL have parameter SYNC_POL, default 1: active level of hsync/vsync (1 = active-high).
REQ-002 SHALL have parameter STABLE_FRAMES, default 2: consecutive identical frames required before timing_valid asserts (range 1..15).
REQ-003 clk  input  1  pixel clock from tmds_decoder; sole clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 locked  input  1  decoder clock/decode lock.
REQ-006 data_valid  input  1  current word is pixel data.
REQ-007 sync_valid  input  1  current channel-0 word is a control word.
REQ-008 sync  input  2  control bits; sync[0] = hsync, sync[1] = vsync.
REQ-009 d0, d1, d2  input  8 each  decoded blue, green and red bytes.
REQ-010 r, g, b  output  8 each  registered pixel bytes: r = d2, g = d1, b = d0.
REQ-011 de  output  1  registered data enable.
REQ-012 hsync, vsync  output  1 each  held sync levels.
REQ-013 x, y  output  12 each  active pixel column and row of the current r/g/b.
REQ-014 frame_start  output  1  one-cycle pulse on the first active pixel of a frame.
REQ-015 width, height  output  12 each  last measured active width and height.
REQ-016 timing_valid  output  1  measurement stable.

Function
REQ-017 SHALL register all outputs, with 1-cycle latency from input to the aligned r/g/b/de/hsync/vsync/x/y/frame_start.
REQ-018 de SHALL equal data_valid && locked, delayed 1 cycle.
REQ-019 hsync and vsync SHALL load sync[0] and sync[1] only when sync_valid=1, and SHALL otherwise hold their value.
REQ-020 vsync edge SHALL mean the held vsync changing to SYNC_POL; de rise SHALL mean de_in=1 with the previous de_in=0; de fall SHALL mean the reverse.
REQ-021 x SHALL be 0 on a de rise, SHALL increment on each further de cycle, and SHALL saturate at 4095; it SHALL hold while de=0.
REQ-022 On de fall, line_len SHALL equal the count of de-high cycles in the line, saturated at 4095.
REQ-023 FSM states SHALL be SEEK, ARMED and ACTIVE.
REQ-024 SEEK SHALL move to ARMED on a vsync edge.
REQ-025 ARMED SHALL move to ACTIVE on a de rise; in that cycle y SHALL be 0 and frame_start SHALL be 1.
REQ-026 In ACTIVE, each de rise SHALL increment y, saturating at 4095.
REQ-027 ACTIVE SHALL move to ARMED on a vsync edge, closing the frame with frame_lines = y+1.
REQ-028 If a vsync edge and a de rise occur in the same cycle while in ACTIVE, the block SHALL close the frame first and then start a new one: state ACTIVE, y=0, frame_start=1.
REQ-029 If locked=0 in any state, the FSM SHALL go to SEEK next cycle, and SHALL clear timing_valid and stable_cnt; width and height SHALL hold.
REQ-030 Within a frame, the block SHALL store the first line_len; any later line_len that differs SHALL set frame_bad, which is cleared at frame start.
REQ-031 On frame close with frame_bad=0, it SHALL update width and height to the frame's values.
REQ-032 On frame close, if the new width and height equal the previous ones and frame_bad=0, stable_cnt SHALL increment, saturating at STABLE_FRAMES.
REQ-033 On frame close, if the values differ, stable_cnt SHALL be 1; if frame_bad=1, stable_cnt SHALL be 0.
REQ-034 timing_valid SHALL be 1 exactly when stable_cnt >= STABLE_FRAMES, registered, and SHALL update the cycle after frame close.
REQ-035 A frame closed with zero lines SHALL be impossible, because ARMED without de never closes a frame.

Reset
REQ-036 While reset=1, all of the following SHALL be 0: r, g, b, de, hsync, vsync, x, y, frame_start, width, height, timing_valid, stable_cnt and frame_bad.
REQ-037 While reset=1, the FSM SHALL be in SEEK.
REQ-038 Reset asserted mid-frame SHALL discard the partial measurement.
REQ-039 After reset deasserts, the first vsync edge SHALL be required before any frame_start.

Verification
REQ-040 Scenario: locked=1, SYNC_POL=1, 3 frames of 640x480 active (800x525 total) -> frame_start once per frame; x runs 0..639 and y runs 0..479; width=640, height=480; timing_valid=1 one cycle after the 2nd frame close.
REQ-041 Scenario: stable 640x480, then one frame with line 100 only 639 pixels -> timing_valid=0 after that frame's close, with width/height held at 640/480; timing_valid=1 again after 2 further good frames.
REQ-042 Scenario: locked dropped for 1 cycle mid-frame -> next cycle state SEEK and timing_valid=0; no frame_start until a vsync edge followed by a de rise.
REQ-043 Scenario: resolution change from 640x480 to 800x600 -> width/height=800/600 after the first new frame, stable_cnt=1, timing_valid=0; timing_valid=1 after the second.
REQ-044 Scenario: vsync edge coincident with a de rise in ACTIVE -> frame closed (height = y+1), frame_start=1 and y=0 in the same output cycle.
REQ-045 Scenario: reset pulsed asynchronously mid-line -> all outputs 0 immediately; after release, r/g/b follow d2/d1/d0 with 1-cycle latency and timing_valid stays 0 until 2 complete frames.
